pe_rx_checker: RTL
==================

PE_RX_CHECKER -- requirements
Module: pe_rx_checker

Interface
REQ-001 Parameter address, default 0: this PE's network address, used for the misroute check.
REQ-002 Parameter numPE, default 4: number of PEs and number of tracked sources.
REQ-003 Parameter AddressWidth, default 2: width of the destination field.
REQ-004 Parameter DataWidth, default 32: width of the payload field.
REQ-005 Parameter TotalWidth, default 35: packet width; must be at least AddressWidth+DataWidth.
REQ-006 Parameter PktLmit, default 100: packets per source; source s sends payloads PktLmit*s .. PktLmit*s+PktLmit-1 in order.
REQ-007 Parameter StallPeriod, default 0: backpressure period; 0 means never stall.
REQ-008 Parameter ExpectedPkts, default 100: accepted-packet count that raises o_done.
REQ-009 Parameter CntWidth, default 16: width of every counter output.
REQ-010 clk  input  1  sole clock; all logic on its rising edge.
REQ-011 rst  input  1  synchronous, active-high reset.
REQ-012 i_data  input  TotalWidth  packet; destination field is [DataWidth+:AddressWidth], payload is [DataWidth-1:0].
REQ-013 i_data_valid  input  1  packet present.
REQ-014 o_data_ready  output  1  registered ready.
REQ-015 o_rcv_count  output  CntWidth  number of accepted packets.
REQ-016 o_misroute_count  output  CntWidth  accepted packets whose destination field is not address.
REQ-017 o_seq_err_count  output  CntWidth  accepted packets that fail the order check.
REQ-018 o_done  output  1  sticky; set once o_rcv_count reaches ExpectedPkts.

Function
REQ-019 A packet SHALL be accepted in a cycle where i_data_valid and o_data_ready are both 1; nothing is accepted in any other cycle.
REQ-020 If StallPeriod=0, o_data_ready SHALL be 1 in every cycle after reset.
REQ-021 If StallPeriod=P>0, a free-running counter SHALL run 0..P-1 and wrap; o_data_ready SHALL be 0 exactly in cycles where the counter equals P-1.
REQ-022 The stall counter SHALL advance whether or not i_data_valid is asserted.
REQ-023 The datapath SHALL have two stages: stage 1 registers the accepted packet and a valid bit; stage 2 classifies the packet and updates the counters.
REQ-024 Counter outputs SHALL reflect a packet accepted at edge N after edge N+1.
REQ-025 Back-to-back acceptances SHALL sustain one packet per cycle with no loss.
REQ-026 Each source s SHALL have an expected register exp[s] of DataWidth bits, reset to PktLmit*s.
REQ-027 The source of a payload d SHALL be the unique s for which PktLmit*s <= d < PktLmit*(s+1), resolved by parallel comparators with no divider.
REQ-028 If d == exp[s], the packet SHALL be in order and exp[s] SHALL become d+1.
REQ-029 If d != exp[s] (gap or duplicate), o_seq_err_count SHALL increment and exp[s] SHALL resync to d+1.
REQ-030 If d >= PktLmit*numPE (no source), o_seq_err_count SHALL increment and no exp register SHALL change.
REQ-031 The misroute check SHALL be independent of the order check; one packet may increment both o_misroute_count and o_seq_err_count.
REQ-032 All counters SHALL saturate at all-ones and never wrap.
REQ-033 o_done SHALL rise in the same cycle o_rcv_count becomes ExpectedPkts and stay 1 until reset.
REQ-034 Packets accepted after o_done is set SHALL still be counted and checked.

Reset
REQ-035 While rst=1 at a rising edge: counters, o_done, the stage-1 valid bit and the stall counter SHALL clear, o_data_ready SHALL be 0, and exp[s] SHALL reload PktLmit*s.
REQ-036 o_data_ready SHALL rise on the first edge after rst is released.
REQ-037 A packet in flight when rst is asserted mid-stream SHALL be discarded and SHALL have no effect on any counter.

Structure
REQ-038 Packet field offsets (destination LSB = DataWidth, destination width = AddressWidth) SHALL live in the shared NoC package or header used by both the PE and the router.
REQ-039 The per-source compare-and-update logic SHALL be one sub-module, pe_rx_seq_tracker, instantiated numPE times with parameter s.

Verification
REQ-040 Parameters address=1, StallPeriod=0; send payloads 0..99 (dest 1), then 100..199 (dest 1) -> o_rcv_count=200, o_seq_err_count=0, o_misroute_count=0, o_done=1 once the count reaches 100.
REQ-041 Send payloads 200, 201, 203 (dest 1) -> o_seq_err_count=1; then send 204 -> no further error (resync verified).
REQ-042 Send one packet with dest=2 to address=1 -> o_misroute_count=1 and o_rcv_count=1.
REQ-043 StallPeriod=4, i_data_valid held at 1 for 40 cycles -> o_data_ready low in cycles 3, 7, 11, ...; o_rcv_count=30; no duplicate and no lost packet.
REQ-044 Send payload 400 with numPE=4 -> o_seq_err_count=1 and every exp register unchanged.
REQ-045 Assert rst in the cycle after an acceptance -> all counters read 0 after reset, exp[s]=100*s, and o_data_ready goes 1 one cycle after release.

Source files
------------

// File: rtl/pe_rx_checker_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pe_rx_checker_pkg: NoC packet field layout shared by PE and router.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pe_rx_checker_pkg;

  localparam int unsigned NOC_DATA_WIDTH  = 32;
  localparam int unsigned NOC_ADDR_WIDTH  = 2;
  localparam int unsigned NOC_TOTAL_WIDTH = 35;
  localparam int unsigned NOC_PAYLOAD_LSB = 0;

  // Destination field sits directly above the payload.
  function automatic int unsigned noc_dest_lsb(input int unsigned data_width);
    return data_width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pe_rx_checker_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pe_rx_checker_if: valid/ready packet link into the PE receiver.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface pe_rx_checker_if
  import pe_rx_checker_pkg::*;
#(
  parameter int unsigned TotalWidth = NOC_TOTAL_WIDTH
);
  logic [TotalWidth-1:0] i_data;
  logic                  i_data_valid;
  logic                  o_data_ready;

  modport master (output i_data, output i_data_valid, input  o_data_ready);
  modport slave  (input  i_data, input  i_data_valid, output o_data_ready);
endinterface
`default_nettype wire

// File: rtl/pe_rx_seq_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pe_rx_seq_tracker: range match and in-order check for one source.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pe_rx_seq_tracker
  import pe_rx_checker_pkg::*;
#(
  parameter int unsigned s         = 0,
  parameter int unsigned PktLmit   = 100,
  parameter int unsigned DataWidth = NOC_DATA_WIDTH
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 i_valid,
  input  wire logic [DataWidth-1:0] i_payload,
  output logic                      o_hit,
  output logic                      o_err
);

  localparam int unsigned c_EXT_W = DataWidth + 1;
  localparam logic [c_EXT_W-1:0] c_LO = c_EXT_W'(PktLmit * s);
  localparam logic [c_EXT_W-1:0] c_HI = c_EXT_W'(PktLmit * (s + 1));

  logic [DataWidth-1:0] r_exp;
  logic [c_EXT_W-1:0]   w_pay_ext;

  // One extra bit keeps the upper bound of the last source from overflowing.
  assign w_pay_ext = {1'b0, i_payload};
  assign o_hit     = (w_pay_ext >= c_LO) && (w_pay_ext < c_HI);
  assign o_err     = o_hit && (i_payload != r_exp);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_exp <= c_LO[DataWidth-1:0];
    end else if (i_valid && o_hit) begin
      r_exp <= i_payload + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pe_rx_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pe_rx_checker: PE receive sink counting, misroute and order checks.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pe_rx_checker
  import pe_rx_checker_pkg::*;
#(
  parameter int unsigned address      = 0,
  parameter int unsigned numPE        = 4,
  parameter int unsigned AddressWidth = NOC_ADDR_WIDTH,
  parameter int unsigned DataWidth    = NOC_DATA_WIDTH,
  parameter int unsigned TotalWidth   = NOC_TOTAL_WIDTH,
  parameter int unsigned PktLmit      = 100,
  parameter int unsigned StallPeriod  = 0,
  parameter int unsigned ExpectedPkts = 100,
  parameter int unsigned CntWidth     = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  pe_rx_checker_if.slave     rx,
  output logic [CntWidth-1:0] o_rcv_count,
  output logic [CntWidth-1:0] o_misroute_count,
  output logic [CntWidth-1:0] o_seq_err_count,
  output logic               o_done
);

  localparam int unsigned c_DEST_LSB = noc_dest_lsb(DataWidth);
  localparam int unsigned c_PKT_W    = DataWidth + AddressWidth;
  localparam int unsigned c_STALL_W  = (StallPeriod > 1) ? $clog2(StallPeriod) : 1;
  localparam logic [CntWidth-1:0]     c_EXPECTED = CntWidth'(ExpectedPkts);
  localparam logic [AddressWidth-1:0] c_ADDR     = AddressWidth'(address);

  logic                  r_ready;
  logic                  w_accept;
  logic                  r_s1_valid;
  logic [c_PKT_W-1:0]    r_s1_pkt;
  logic [DataWidth-1:0]  w_payload;
  logic [AddressWidth-1:0] w_dest;
  logic [numPE-1:0]      w_hit;
  logic [numPE-1:0]      w_err;
  logic                  w_seq_err;
  logic                  w_misroute;
  logic [CntWidth-1:0]   r_rcv, r_mis, r_err;
  logic [CntWidth-1:0]   w_rcv_next, w_mis_next, w_err_next;
  logic                  r_done;
  logic                  w_unused_hi;

  generate
    if (StallPeriod == 0) begin : g_nostall
      always_ff @(posedge clk) begin
        r_ready <= !rst;
      end
    end else begin : g_stall
      localparam logic [c_STALL_W-1:0] c_LAST = c_STALL_W'(StallPeriod - 1);
      logic [c_STALL_W-1:0] r_stall_cnt;
      logic [c_STALL_W-1:0] w_stall_next;
      logic                 r_run;

      // r_run holds the count at 0 for the first cycle ready is visible.
      always_comb begin
        w_stall_next = r_stall_cnt;
        if (r_run) begin
          w_stall_next = (r_stall_cnt == c_LAST) ? '0 : r_stall_cnt + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_stall_cnt <= '0;
          r_run       <= 1'b0;
          r_ready     <= 1'b0;
        end else begin
          r_stall_cnt <= w_stall_next;
          r_run       <= 1'b1;
          r_ready     <= (w_stall_next != c_LAST);
        end
      end
    end

    if (TotalWidth > c_PKT_W) begin : g_hi_bits
      assign w_unused_hi = ^rx.i_data[TotalWidth-1:c_PKT_W];
    end else begin : g_no_hi_bits
      assign w_unused_hi = 1'b0;
    end
  endgenerate

  assign rx.o_data_ready = r_ready;
  assign w_accept        = rx.i_data_valid && r_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
    end
    if (w_accept) begin
      r_s1_pkt <= rx.i_data[c_PKT_W-1:0];
    end
  end

  assign w_payload = r_s1_pkt[DataWidth-1:0];
  assign w_dest    = r_s1_pkt[c_DEST_LSB +: AddressWidth];

  generate
    for (genvar gi = 0; gi < numPE; gi++) begin : g_trk
      pe_rx_seq_tracker #(
        .s         (gi),
        .PktLmit   (PktLmit),
        .DataWidth (DataWidth)
      ) u_trk (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (r_s1_valid),
        .i_payload (w_payload),
        .o_hit     (w_hit[gi]),
        .o_err     (w_err[gi])
      );
    end
  endgenerate

  // A payload matching no source range is an order error on its own.
  assign w_seq_err  = (w_hit == '0) || (|w_err);
  assign w_misroute = (w_dest != c_ADDR);

  always_comb begin
    w_rcv_next = r_rcv;
    w_mis_next = r_mis;
    w_err_next = r_err;
    if (r_s1_valid) begin
      if (r_rcv != '1) w_rcv_next = r_rcv + 1'b1;
      if (w_misroute && (r_mis != '1)) w_mis_next = r_mis + 1'b1;
      if (w_seq_err && (r_err != '1)) w_err_next = r_err + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rcv  <= '0;
      r_mis  <= '0;
      r_err  <= '0;
      r_done <= 1'b0;
    end else begin
      r_rcv  <= w_rcv_next;
      r_mis  <= w_mis_next;
      r_err  <= w_err_next;
      r_done <= r_done || (w_rcv_next >= c_EXPECTED);
    end
  end

  assign o_rcv_count      = r_rcv;
  assign o_misroute_count = r_mis;
  assign o_seq_err_count  = r_err;
  assign o_done           = r_done;

endmodule
`default_nettype wire
